// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants
package riscv_pkg;
    typedef enum logic [2:0] {REQ, WAIT, HOLD, DROP, ERR} fetch_state_t;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage owning the PC, one outstanding imem request, valid/ready to decode
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        misaligned_err
);
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
    logic         err_q, err_d;
    logic         accept, bad;

    assign accept         = (state_q == REQ) && imem_req_ready;
    assign bad            = redirect_pc[1:0] != 2'b00;
    assign imem_req_valid = state_q == REQ;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = state_q == HOLD;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign misaligned_err = err_q;

    // next state: a redirect always wins; in-flight responses are dropped after it
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        err_d      = err_q;
        if (redirect_valid) begin
            pc_d  = redirect_pc;
            err_d = bad ? 1'b1 : (state_q == ERR) ? 1'b0 : err_q;
        end
        case (state_q)
            REQ: begin
                if (redirect_valid) state_d = accept ? DROP : bad ? ERR : REQ;
                else if (accept) state_d = WAIT;
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? (bad ? ERR : REQ) : DROP;
                end else if (imem_rsp_valid) begin
                    instr_d    = imem_rsp_data;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 32'(INSTR_BYTES);
                    state_d    = HOLD;
                end
            end
            DROP:    if (imem_rsp_valid) state_d = err_d ? ERR : REQ;
            HOLD:    if (redirect_valid) state_d = bad ? ERR : REQ;
                     else if (instr_ready) state_d = REQ;
            ERR:     if (redirect_valid && !bad) state_d = REQ;
            default: state_d = REQ;
        endcase
    end

    // state, pc and held instruction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            err_q      <= err_d;
        end
    end
endmodule
